// File: rtl/galvo_setup_sequencer.sv
// Galvo setup sequencer: on a setup_start rising edge, traces the calibration square
// LOOPS times over a valid/ready DAC handshake, then parks at centre and pulses setup_done.
module galvo_setup_sequencer #(
  parameter int DAC_W = 12,
  parameter int DWELL = 50000,
  parameter int LOOPS = 4,
  parameter int X_MIN = 512,
  parameter int X_MAX = 3584,
  parameter int Y_MIN = 512,
  parameter int Y_MAX = 3584
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             setup_start,
  input  logic             dac_ready,
  output logic             dac_valid,
  output logic [DAC_W-1:0] x_out,
  output logic [DAC_W-1:0] y_out,
  output logic             laser_en,
  output logic             busy,
  output logic             setup_done
);

  localparam int DCW = $clog2(DWELL + 1);
  localparam int LCW = $clog2(LOOPS + 1);
  localparam int DW1 = DAC_W + 1;

  localparam logic [DCW-1:0]   DWELL_LAST = DCW'(DWELL - 1);
  localparam logic [LCW-1:0]   LOOP_LAST  = LCW'(LOOPS - 1);
  localparam bit               NO_DWELL   = (DWELL == 1);

  localparam logic [DAC_W-1:0] XL = DAC_W'(X_MIN);
  localparam logic [DAC_W-1:0] XR = DAC_W'(X_MAX);
  localparam logic [DAC_W-1:0] YB = DAC_W'(Y_MIN);
  localparam logic [DAC_W-1:0] YT = DAC_W'(Y_MAX);

  // Centre is the halved sum taken one bit wider than the DAC so it cannot overflow.
  localparam logic [DAC_W:0]   X_SUM = DW1'(X_MIN) + DW1'(X_MAX);
  localparam logic [DAC_W:0]   Y_SUM = DW1'(Y_MIN) + DW1'(Y_MAX);
  localparam logic [DAC_W-1:0] CX    = X_SUM[DAC_W:1];
  localparam logic [DAC_W-1:0] CY    = Y_SUM[DAC_W:1];

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_DWELL,
    S_NEXT,
    S_PARK,
    S_PARK_DWELL,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [LCW-1:0]   loop_q, loop_d;
  logic [DCW-1:0]   dwell_q, dwell_d;
  logic [DCW-1:0]   dwell_inc;
  logic [DAC_W-1:0] x_d, y_d;
  logic             laser_d;
  logic             start_q;
  logic             start_edge;

  // Corner order runs counter-clockwise from bottom-left.
  function automatic logic [DAC_W-1:0] corner_x(input logic [1:0] i);
    return (i == 2'd1 || i == 2'd2) ? XR : XL;
  endfunction

  function automatic logic [DAC_W-1:0] corner_y(input logic [1:0] i);
    return i[1] ? YT : YB;
  endfunction

  assign start_edge = setup_start & ~start_q;
  assign dwell_inc  = dwell_q + DCW'(1);

  assign dac_valid  = (state_q == S_SEND) || (state_q == S_PARK);
  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign setup_done = (state_q == S_DONE);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    loop_d  = loop_q;
    dwell_d = dwell_q;
    x_d     = x_out;
    y_d     = y_out;
    laser_d = laser_en;

    unique case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          state_d = S_SEND;
          idx_d   = 2'd0;
          loop_d  = '0;
          x_d     = corner_x(2'd0);
          y_d     = corner_y(2'd0);
          laser_d = 1'b0;
        end
      end

      S_SEND: begin
        if (dac_ready) begin
          dwell_d = '0;
          state_d = NO_DWELL ? S_NEXT : S_DWELL;
        end
      end

      // The NEXT cycle is the last hold cycle, so the DWELL state lasts DWELL-1 cycles.
      S_DWELL: begin
        dwell_d = dwell_inc;
        if (dwell_inc == DWELL_LAST) state_d = S_NEXT;
      end

      S_NEXT: begin
        if (idx_q != 2'd3) begin
          idx_d   = idx_q + 2'd1;
          state_d = S_SEND;
          x_d     = corner_x(idx_q + 2'd1);
          y_d     = corner_y(idx_q + 2'd1);
          laser_d = 1'b1;
        end else if (loop_q != LOOP_LAST) begin
          idx_d   = 2'd0;
          loop_d  = loop_q + LCW'(1);
          state_d = S_SEND;
          x_d     = corner_x(2'd0);
          y_d     = corner_y(2'd0);
          laser_d = 1'b1;
        end else begin
          state_d = S_PARK;
          x_d     = CX;
          y_d     = CY;
          laser_d = 1'b0;
        end
      end

      S_PARK: begin
        if (dac_ready) begin
          dwell_d = '0;
          state_d = NO_DWELL ? S_DONE : S_PARK_DWELL;
        end
      end

      S_PARK_DWELL: begin
        dwell_d = dwell_inc;
        if (dwell_inc == DWELL_LAST) state_d = S_DONE;
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values;
  // all registers take the asynchronous reset, there is no storage array to leave unreset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      idx_q    <= 2'd0;
      loop_q   <= '0;
      dwell_q  <= '0;
      start_q  <= 1'b0;
      x_out    <= CX;
      y_out    <= CY;
      laser_en <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      loop_q   <= loop_d;
      dwell_q  <= dwell_d;
      start_q  <= setup_start;
      x_out    <= x_d;
      y_out    <= y_d;
      laser_en <= laser_d;
    end
  end

endmodule

// File: tb/tb_galvo_setup_sequencer.sv
// Self-checking bench for galvo_setup_sequencer: a cycle vector table, hand-built corner
// sequences and randomized dac_ready runs compared against a cycle-timing reference model.
module tb_galvo_setup_sequencer;

  localparam int DAC_W = 12;
  localparam int DWELL = 3;
  localparam int LOOPS = 2;
  localparam int X_MIN = 512;
  localparam int X_MAX = 3584;
  localparam int Y_MIN = 512;
  localparam int Y_MAX = 3584;
  localparam int CX    = (X_MIN + X_MAX) / 2;
  localparam int CY    = (Y_MIN + Y_MAX) / 2;
  localparam int NXF   = 4 * LOOPS + 1;
  localparam int LOGN  = 4096;
  localparam int POST  = 8;

  typedef enum int {RM_MANUAL, RM_ONE, RM_RAND, RM_SPARSE, RM_STALL} rmode_e;

  typedef struct {
    logic rst, start, ready;
    logic valid, laser, busy, done;
    int   x, y;
  } vec_t;

  typedef struct {
    int   x, y;
    logic laser;
    int   cyc;
  } xfer_t;

  logic             clk = 1'b0;
  logic             clk_en = 1'b1;
  logic             reset = 1'b1;
  logic             setup_start = 1'b0;
  logic             dac_ready = 1'b0;
  logic             dac_valid, laser_en, busy, setup_done;
  logic [DAC_W-1:0] x_out, y_out;

  int     cyc;
  int     tests = 0;
  int     fails = 0;
  rmode_e ready_mode = RM_MANUAL;
  int     stall_from = 0;

  bit     ready_log [LOGN];
  bit     valid_log [LOGN];
  bit     laser_log [LOGN];
  bit     busy_log  [LOGN];
  xfer_t  xfer_q [$];
  int     done_q [$];
  int     unstable;
  bit     pend;
  bit     pl;
  logic [DAC_W-1:0] px, py;

  galvo_setup_sequencer #(
    .DAC_W(DAC_W), .DWELL(DWELL), .LOOPS(LOOPS),
    .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .setup_start (setup_start),
    .dac_ready   (dac_ready),
    .dac_valid   (dac_valid),
    .x_out       (x_out),
    .y_out       (y_out),
    .laser_en    (laser_en),
    .busy        (busy),
    .setup_done  (setup_done)
  );

  always #5 if (clk_en) clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe at the falling edge: log per-cycle outputs, capture transfers and done pulses,
  // and flag any point that moves or drops valid while it is waiting for ready.
  always @(negedge clk) begin
    if (cyc < LOGN) begin
      ready_log[cyc] <= dac_ready;
      valid_log[cyc] <= dac_valid;
      laser_log[cyc] <= laser_en;
      busy_log[cyc]  <= busy;
    end
    if (reset) begin
      pend <= 1'b0;
    end else begin
      if (dac_valid && dac_ready) xfer_q.push_back(xfer_t'{int'(x_out), int'(y_out), laser_en, cyc});
      if (setup_done) done_q.push_back(cyc);
      if (pend && (!dac_valid || x_out != px || y_out != py || laser_en != pl)) unstable <= unstable + 1;
      pend <= dac_valid && !dac_ready;
      px   <= x_out;
      py   <= y_out;
      pl   <= laser_en;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    case (ready_mode)
      RM_ONE:    dac_ready = 1'b1;
      RM_RAND:   dac_ready = ($urandom_range(0, 3) != 0);
      RM_SPARSE: dac_ready = ($urandom_range(0, 3) == 0);
      RM_STALL:  dac_ready = !(cyc >= stall_from && cyc < stall_from + 10);
      default:   ;
    endcase
  endtask

  // Reference: point k is offered DWELL+1 cycles after transfer k-1 (the first one the
  // cycle after the start edge), is taken on the first cycle with ready high, and
  // setup_done follows the park transfer by DWELL cycles.
  task automatic finish_run(input string tag, input int e, input bit noise, input int ubase);
    int tk [NXF];
    int vf [NXF];
    int nv, t, d, n, vm, lm, bm, idx, ex, ey, el;
    bit ev, elz, eb;
    n = 0;
    while (done_q.size() == 0 && n < 1500) begin
      tick();
      if (noise && cyc < e + 15) setup_start = 1'($urandom_range(0, 1));
      else setup_start = 1'b1;
      n++;
    end
    check($sformatf("%s done seen", tag), int'(done_q.size() > 0), 1);
    repeat (POST) tick();

    nv = e + 1;
    for (int k = 0; k < NXF; k++) begin
      t = nv;
      while (t < cyc && t < LOGN - 1 && !ready_log[t]) t++;
      vf[k] = nv;
      tk[k] = t;
      nv = t + DWELL + 1;
    end
    d = tk[NXF-1] + DWELL;

    check($sformatf("%s xfer count", tag), xfer_q.size(), NXF);
    for (int k = 0; k < NXF && k < xfer_q.size(); k++) begin
      idx = k % 4;
      if (k == NXF - 1) begin
        ex = CX; ey = CY; el = 0;
      end else begin
        ex = (idx == 1 || idx == 2) ? X_MAX : X_MIN;
        ey = (idx >= 2) ? Y_MAX : Y_MIN;
        el = (k == 0) ? 0 : 1;
      end
      check($sformatf("%s xfer%0d x", tag, k), xfer_q[k].x, ex);
      check($sformatf("%s xfer%0d y", tag, k), xfer_q[k].y, ey);
      check($sformatf("%s xfer%0d laser", tag, k), int'(xfer_q[k].laser), el);
      check($sformatf("%s xfer%0d cycle", tag, k), xfer_q[k].cyc - e, tk[k] - e);
    end
    check($sformatf("%s done pulses", tag), done_q.size(), 1);
    if (done_q.size() > 0) check($sformatf("%s done cycle", tag), done_q[0] - e, d - e);

    vm = 0; lm = 0; bm = 0;
    for (int c = e; c < cyc && c < LOGN; c++) begin
      ev = 1'b0;
      for (int k = 0; k < NXF; k++) if (c >= vf[k] && c <= tk[k]) ev = 1'b1;
      elz = (c >= vf[1] && c < vf[NXF-1]);
      eb  = (c > e && c < d);
      if (valid_log[c] != ev) vm++;
      if (laser_log[c] != elz) lm++;
      if (busy_log[c] != eb) bm++;
    end
    check($sformatf("%s valid profile errors", tag), vm, 0);
    check($sformatf("%s laser profile errors", tag), lm, 0);
    check($sformatf("%s busy profile errors", tag), bm, 0);
    check($sformatf("%s unstable points", tag), unstable - ubase, 0);
  endtask

  task automatic run_and_check(input string tag, input rmode_e mode, input bit noise, input int stall_off);
    int e, ub;
    ready_mode = mode;
    setup_start = 1'b0;
    tick();
    tick();
    ub = unstable;
    xfer_q.delete();
    done_q.delete();
    setup_start = 1'b1;
    e = cyc;
    stall_from = e + stall_off;
    finish_run(tag, e, noise, ub);
  endtask

  initial begin
    vec_t vt [12];
    int   e, ub;
    bit   bs;

    //            rst start rdy  valid laser busy done  x     y
    vt[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2048, 2048};
    vt[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2048, 2048};
    vt[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2048, 2048};
    vt[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,  512,  512};
    vt[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,  512,  512};
    vt[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0,  512,  512};
    vt[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,  512,  512};
    vt[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,  512,  512};
    vt[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,  512,  512};
    vt[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3584,  512};
    vt[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3584,  512};
    vt[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3584,  512};

    for (int i = 0; i < 12; i++) begin
      tick();
      reset       = vt[i].rst;
      setup_start = vt[i].start;
      dac_ready   = vt[i].ready;
      @(negedge clk);
      check($sformatf("vec%0d valid", i), int'(dac_valid),  int'(vt[i].valid));
      check($sformatf("vec%0d laser", i), int'(laser_en),   int'(vt[i].laser));
      check($sformatf("vec%0d busy", i),  int'(busy),       int'(vt[i].busy));
      check($sformatf("vec%0d done", i),  int'(setup_done), int'(vt[i].done));
      check($sformatf("vec%0d x", i),     int'(x_out),      vt[i].x);
      check($sformatf("vec%0d y", i),     int'(y_out),      vt[i].y);
    end

    // Reset with the clock stopped must still clear the outputs at once.
    clk_en = 1'b0;
    #40;
    check("clkstop pre laser", int'(laser_en), 1);
    reset = 1'b1;
    #2;
    check("clkstop valid", int'(dac_valid), 0);
    check("clkstop laser", int'(laser_en), 0);
    check("clkstop busy", int'(busy), 0);
    check("clkstop x", int'(x_out), CX);
    check("clkstop y", int'(y_out), CY);
    #20;
    clk_en = 1'b1;
    ready_mode = RM_ONE;
    setup_start = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    repeat (3) tick();
    check("idle after reset busy", int'(busy), 0);

    run_and_check("run_ready", RM_ONE, 1'b0, 0);

    xfer_q.delete();
    bs = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      bs |= busy;
    end
    check("held start busy", int'(bs), 0);
    check("held start xfers", xfer_q.size(), 0);

    run_and_check("second_run", RM_ONE, 1'b0, 0);
    run_and_check("stall_first", RM_STALL, 1'b0, 1);
    run_and_check("stall_mid", RM_STALL, 1'b0, 6);
    run_and_check("edges_busy", RM_ONE, 1'b1, 0);

    // Reset in the dwell of loop 1, idx 0 (transfer k=4 at e+17).
    ready_mode = RM_ONE;
    setup_start = 1'b0;
    tick();
    tick();
    setup_start = 1'b1;
    e = cyc;
    while (cyc < e + 18) tick();
    check("l1 dwell laser", int'(laser_en), 1);
    check("l1 dwell x", int'(x_out), X_MIN);
    check("l1 dwell valid", int'(dac_valid), 0);
    reset = 1'b1;
    #1;
    check("midrun reset valid", int'(dac_valid), 0);
    check("midrun reset laser", int'(laser_en), 0);
    check("midrun reset busy", int'(busy), 0);
    check("midrun reset x", int'(x_out), CX);
    check("midrun reset y", int'(y_out), CY);
    tick();
    tick();
    setup_start = 1'b0;
    reset = 1'b0;
    tick();
    run_and_check("after_reset", RM_ONE, 1'b0, 0);

    // setup_start already high when reset releases counts as a start edge.
    reset = 1'b1;
    setup_start = 1'b1;
    tick();
    tick();
    ub = unstable;
    xfer_q.delete();
    done_q.delete();
    tick();
    reset = 1'b0;
    e = cyc;
    tick();
    tick();
    check("busy 2 after release", int'(busy), 1);
    finish_run("start_at_release", e, 1'b0, ub);

    for (int r = 0; r < 4; r++) begin
      run_and_check($sformatf("rand%0d", r), (r % 2 == 0) ? RM_RAND : RM_SPARSE,
                    1'($urandom_range(0, 1)), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
